// File: rtl/pipelined_carry_adder_if.sv
// Operand/result bus for pipelined_carry_adder: valid/ready in, valid/ready out.
// The ovf signal exists only when PCA_OVERFLOW_EN is defined.
interface pipelined_carry_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef PCA_OVERFLOW_EN
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
`else
   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout
   );
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout
   );
`endif
endinterface

// File: rtl/pipelined_carry_adder.sv
// Pipelined carry-chain adder/subtractor: STAGES ripple slices with registered carries.
// Define PCA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module pipelined_carry_adder #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   pipelined_carry_adder_if.slave bus
);
   localparam int unsigned C  = WIDTH / STAGES;
   localparam int unsigned CW = C + 1;

   // Stage k holds the beat before slice k has been added.
   logic [WIDTH-1:0]  a_q     [STAGES];
   logic [WIDTH-1:0]  bp_q    [STAGES];
   logic [WIDTH-1:0]  s_q     [STAGES];
   logic              c_q     [STAGES];
   logic [STAGES-1:0] v_q;

   logic [CW-1:0]     slice_c [STAGES];
   logic [WIDTH-1:0]  s_nxt_c [STAGES];
   logic              c_nxt_c [STAGES];
   logic [STAGES:0]   en_c;

   logic              out_valid_q;
   logic [WIDTH-1:0]  sum_q;
   logic              cout_q;
`ifdef PCA_OVERFLOW_EN
   logic              ovf_q;
`endif

   // Slice k ripple add on the beat held in stage k.
   always_comb begin
      for (int unsigned k = 0; k < STAGES; k++) begin
         slice_c[k] = {1'b0, a_q[k][k*C +: C]} + {1'b0, bp_q[k][k*C +: C]} + CW'(c_q[k]);
         s_nxt_c[k] = s_q[k];
         s_nxt_c[k][k*C +: C] = slice_c[k][C-1:0];
         c_nxt_c[k] = slice_c[k][C];
      end
   end

   // Ready chain from the output back to stage 0; an empty register always loads.
   always_comb begin
      en_c = '0;
      en_c[STAGES] = !out_valid_q || bus.out_ready;
      for (int k = int'(STAGES) - 1; k >= 0; k--) begin
         en_c[k] = !v_q[k] || en_c[k+1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q         <= '0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
`ifdef PCA_OVERFLOW_EN
         ovf_q       <= 1'b0;
`endif
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k]  <= '0;
            bp_q[k] <= '0;
            s_q[k]  <= '0;
            c_q[k]  <= 1'b0;
         end
      end else begin
         if (en_c[0]) begin
            v_q[0] <= bus.in_valid;
            if (bus.in_valid) begin
               a_q[0]  <= bus.a;
               bp_q[0] <= bus.sub ? ~bus.b : bus.b;
               s_q[0]  <= '0;
               c_q[0]  <= bus.sub | bus.cin;
            end
         end
         for (int unsigned k = 1; k < STAGES; k++) begin
            if (en_c[k]) begin
               v_q[k] <= v_q[k-1];
               if (v_q[k-1]) begin
                  a_q[k]  <= a_q[k-1];
                  bp_q[k] <= bp_q[k-1];
                  s_q[k]  <= s_nxt_c[k-1];
                  c_q[k]  <= c_nxt_c[k-1];
               end
            end
         end
         // Output register takes the last slice; data only moves with a valid beat.
         if (en_c[STAGES]) begin
            out_valid_q <= v_q[STAGES-1];
            if (v_q[STAGES-1]) begin
               sum_q  <= s_nxt_c[STAGES-1];
               cout_q <= c_nxt_c[STAGES-1];
`ifdef PCA_OVERFLOW_EN
               ovf_q  <= (a_q[STAGES-1][WIDTH-1] == bp_q[STAGES-1][WIDTH-1]) &&
                         (s_nxt_c[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
`endif
            end
         end
      end
   end

   assign bus.in_ready  = en_c[0];
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
`ifdef PCA_OVERFLOW_EN
   assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder (WIDTH=16, STAGES=4).
// Works with or without PCA_OVERFLOW_EN; ovf is compared only when it exists.
module tb_pipelined_carry_adder;
   localparam int unsigned W = 16;
   localparam int unsigned S = 4;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      res_t         exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   pipelined_carry_adder_if #(.WIDTH(W)) bus ();
   pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   acc_cnt = 0;
   int   con_cnt = 0;
   res_t expq[$];
   logic hold_pend = 1'b0;
   res_t hold_val;
   logic last_ov   = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      res_t   r;
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint t;
      longint sr;
      longint lim = longint'(1) <<< (W - 1);
      if (sub) begin
         r.sum  = W'(ua - ub);
         r.cout = (ua >= ub);
         sr     = sa - sb;
      end else begin
         t      = ua + ub + longint'(cin);
         r.sum  = W'(t);
         r.cout = ((t >>> W) != 0);
         sr     = sa + sb + longint'(cin);
      end
      r.ovf = (sr >= lim) || (sr < -lim);
      return r;
   endfunction

   function automatic res_t mask(input res_t r);
      res_t m = r;
`ifndef PCA_OVERFLOW_EN
      m.ovf = 1'b0;
`endif
      return m;
   endfunction

   function automatic res_t actual();
      res_t r;
      r.sum  = bus.sum;
      r.cout = bus.cout;
`ifdef PCA_OVERFLOW_EN
      r.ovf  = bus.ovf;
`else
      r.ovf  = 1'b0;
`endif
      return r;
   endfunction

   function automatic vec_t mkv(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                input logic sub, input logic [W-1:0] s, input logic co,
                                input logic ov);
      vec_t v;
      v.a = a; v.b = b; v.cin = cin; v.sub = sub;
      v.exp.sum = s; v.exp.cout = co; v.exp.ovf = ov;
      return v;
   endfunction

   // One clock: drive at negedge, then sample handshakes and outputs 1 time unit later.
   task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic icin, input logic isub, input logic iord, input res_t iexp);
      @(negedge clk);
      bus.in_valid  = iv;
      bus.a         = ia;
      bus.b         = ib;
      bus.cin       = icin;
      bus.sub       = isub;
      bus.out_ready = iord;
      #1;
      if (hold_pend)
         chk("hold_stable", 64'({bus.out_valid, actual()}), 64'({1'b1, hold_val}));
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_val  = actual();
      last_ov   = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
         con_cnt++;
         if (expq.size() == 0) chk("spurious_result", 64'(actual()), 64'(0));
         else                  chk("result", 64'(actual()), 64'(expq.pop_front()));
      end
      if (bus.in_valid && bus.in_ready) begin
         acc_cnt++;
         expq.push_back(mask(iexp));
      end
   endtask

   task automatic idle(input logic ord);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, ord, '0);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && expq.size() != 0; i++) idle(1'b1);
      idle(1'b1);
      chk("drain_left", 64'(expq.size()), 64'(0));
   endtask

   task automatic rnd_beat(input logic iv, input logic ord);
      logic [W-1:0] ra = W'($urandom);
      logic [W-1:0] rb = W'($urandom);
      logic         rc = 1'($urandom);
      logic         rs = 1'($urandom);
      cycle(iv, ra, rb, rc, rs, ord, model(ra, rb, rc, rs));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[9];
      int   lat;
      tbl[0] = mkv(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      tbl[1] = mkv(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      tbl[2] = mkv(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      tbl[3] = mkv(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      tbl[4] = mkv(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      tbl[5] = mkv(16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      tbl[6] = mkv(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
      tbl[7] = mkv(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      tbl[8] = mkv(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_state", 64'({bus.out_valid, actual()}), 64'(0));
      rst = 1'b0;
      idle(1'b0);
      chk("in_ready_after_reset", 64'(bus.in_ready), 64'(1));

      // Latency: accept on call 0, first valid sample lands on call S+1.
      cycle(1'b1, tbl[0].a, tbl[0].b, tbl[0].cin, tbl[0].sub, 1'b1, tbl[0].exp);
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         idle(1'b1);
         if (last_ov && lat < 0) lat = i - 1;
      end
      chk("latency", 64'(lat), 64'(S));

      foreach (tbl[i]) begin
         cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1, tbl[i].exp);
         drain();
      end

      // Back-to-back stream at full throughput.
      acc_cnt = 0; con_cnt = 0;
      for (int i = 0; i < 100; i++) rnd_beat(1'b1, 1'b1);
      chk("stream_accepted", 64'(acc_cnt), 64'(100));
      chk("stream_consumed", 64'(con_cnt), 64'(100 - S - 1));
      drain();
      chk("stream_total", 64'(con_cnt), 64'(100));

      // Backpressure: pipeline plus output register hold S+1 beats.
      acc_cnt = 0;
      for (int i = 0; i < 10; i++) rnd_beat(1'b1, 1'b0);
      chk("bp_accepted", 64'(acc_cnt), 64'(S + 1));
      chk("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
      con_cnt = 0;
      drain();
      chk("bp_drained", 64'(con_cnt), 64'(S + 1));

      for (int i = 0; i < 300; i++) rnd_beat(1'($urandom), ($urandom_range(0, 2) != 0));
      drain();

      // Reset with a held result and further beats in flight.
      for (int i = 0; i < 6; i++)
         cycle(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, model(16'h1234, 16'h1111, 1'b0, 1'b0));
      chk("pre_reset_valid", 64'(last_ov), 64'(1));
      @(negedge clk);
      #2;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      chk("async_reset_outputs", 64'({bus.out_valid, actual()}), 64'(0));
      expq.delete();
      hold_pend = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      con_cnt = 0;
      for (int i = 0; i < 12; i++) idle(1'b1);
      chk("no_stale_after_reset", 64'(con_cnt), 64'(0));
      chk("in_ready_after_midreset", 64'(bus.in_ready), 64'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
